// File: rtl/tank_plant_model.sv
// Tank plant model: integrates the water level each clock from inflow and the
// two pump commands, derives the I/S level sensors from thresholds, keeps
// sticky overflow/dry-run alarms and counts pump starts.
// All outputs are registered, so there is no combinational path from the
// controller's commands back to its sensor inputs.
module tank_plant_model #(
    parameter int unsigned LEVEL_W    = 8,
    parameter int unsigned LEVEL_MAX  = 200,
    parameter int unsigned LEVEL_INIT = 100,
    parameter int unsigned THRESH_I   = 50,
    parameter int unsigned THRESH_S   = 150,
    parameter int unsigned INFLOW     = 2,
    parameter int unsigned PUMP_RATE  = 3,
    // Reset value of both start counters; nonzero only to reach saturation quickly.
    parameter int unsigned START_INIT = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inflow_en,
    input  logic [1:0]         pumps,
    input  logic               clear_alarms,
    output logic [1:0]         level_sensors,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow,
    output logic               dry_run,
    output logic [15:0]        b1_starts,
    output logic [15:0]        b2_starts
);

    // Three guard bits: enough headroom for inflow and two pumps without wrapping.
    localparam int unsigned RAW_W = LEVEL_W + 3;

    localparam logic signed [RAW_W-1:0] MAX_S      = RAW_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0]      LVL_MAX_C  = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0]      LVL_INIT_C = LEVEL_W'(LEVEL_INIT);
    localparam logic [LEVEL_W-1:0]      THR_I_C    = LEVEL_W'(THRESH_I);
    localparam logic [LEVEL_W-1:0]      THR_S_C    = LEVEL_W'(THRESH_S);
    localparam logic [1:0]              SENS_INIT  = {LVL_INIT_C >= THR_S_C,
                                                      LVL_INIT_C >= THR_I_C};
    localparam logic [15:0]             CNT_INIT   = 16'(START_INIT);
    localparam logic [15:0]             CNT_SAT    = 16'hFFFF;

    if (THRESH_S <= THRESH_I || 64'(LEVEL_MAX) >= (64'd1 << LEVEL_W) ||
        LEVEL_INIT > LEVEL_MAX) begin : g_bad_params
        $error("tank_plant_model: illegal parameter set");
    end

    logic [LEVEL_W-1:0]      r_level;
    logic [1:0]              r_sensors;
    logic                    r_overflow;
    logic                    r_dry_run;
    logic [15:0]             r_b1_starts;
    logic [15:0]             r_b2_starts;
    logic [1:0]              r_prev_pumps;

    logic signed [RAW_W-1:0] w_in;
    logic signed [RAW_W-1:0] w_out;
    logic signed [RAW_W-1:0] w_raw;
    logic                    w_over;
    logic                    w_under;
    logic                    w_dry_set;
    logic [LEVEL_W-1:0]      w_next_level;
    logic [1:0]              w_next_sensors;
    logic                    w_b1_rise;
    logic                    w_b2_rise;

    // Unsaturated next level, saturation and alarm/start conditions.
    always_comb begin
        w_in           = inflow_en ? RAW_W'(INFLOW) : '0;
        w_out          = RAW_W'(PUMP_RATE * (32'(pumps[0]) + 32'(pumps[1])));
        w_raw          = $signed({3'b000, r_level}) + w_in - w_out;
        w_over         = w_raw > MAX_S;
        w_under        = w_raw[RAW_W-1];
        w_dry_set      = w_under && (pumps != 2'b00);
        w_next_level   = w_raw[LEVEL_W-1:0];
        if (w_over) begin
            w_next_level = LVL_MAX_C;
        end else if (w_under) begin
            w_next_level = '0;
        end
        w_next_sensors = {w_next_level >= THR_S_C, w_next_level >= THR_I_C};
        w_b1_rise      = pumps[0] & ~r_prev_pumps[0];
        w_b2_rise      = pumps[1] & ~r_prev_pumps[1];
    end

    // Level and sensor registers, both taken from the saturated new level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_level   <= LVL_INIT_C;
            r_sensors <= SENS_INIT;
        end else begin
            r_level   <= w_next_level;
            r_sensors <= w_next_sensors;
        end
    end

    // Sticky alarms; a set condition in the same cycle beats clear_alarms.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_dry_run  <= 1'b0;
        end else begin
            r_overflow <= w_over | (r_overflow & ~clear_alarms);
            r_dry_run  <= w_dry_set | (r_dry_run & ~clear_alarms);
        end
    end

    // Saturating pump-start counters driven by rising edges of each pump command.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_b1_starts  <= CNT_INIT;
            r_b2_starts  <= CNT_INIT;
            r_prev_pumps <= 2'b00;
        end else begin
            if (w_b1_rise && r_b1_starts != CNT_SAT) begin
                r_b1_starts <= r_b1_starts + 16'd1;
            end
            if (w_b2_rise && r_b2_starts != CNT_SAT) begin
                r_b2_starts <= r_b2_starts + 16'd1;
            end
            r_prev_pumps <= pumps;
        end
    end

    assign level         = r_level;
    assign level_sensors = r_sensors;
    assign overflow      = r_overflow;
    assign dry_run       = r_dry_run;
    assign b1_starts     = r_b1_starts;
    assign b2_starts     = r_b2_starts;

endmodule

// File: tb/tb_tank_plant_model.sv
// Self-checking bench for tank_plant_model: a driver applies directed and
// random stimulus and pushes the reference model's expected state into a
// queue; a monitor pops one entry after every rising edge and compares.
`timescale 1ns/1ps
module tb_tank_plant_model;

    localparam int LMAX   = 200;
    localparam int LINIT  = 100;
    localparam int TH_I   = 50;
    localparam int TH_S   = 150;
    localparam int INF    = 2;
    localparam int RATE   = 3;
    localparam int SAT_IN = 'hFFFD;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       inflow_en = 1'b0;
    logic [1:0] pumps = 2'b00;
    logic       clear_alarms = 1'b0;

    logic [1:0]  level_sensors, s_level_sensors;
    logic [7:0]  level, s_level;
    logic        overflow, dry_run, s_overflow, s_dry_run;
    logic [15:0] b1_starts, b2_starts, s_b1_starts, s_b2_starts;

    tank_plant_model dut (
        .clock(clock), .reset(reset), .inflow_en(inflow_en), .pumps(pumps),
        .clear_alarms(clear_alarms), .level_sensors(level_sensors), .level(level),
        .overflow(overflow), .dry_run(dry_run), .b1_starts(b1_starts),
        .b2_starts(b2_starts)
    );

    // Same plant with counters starting just below saturation.
    tank_plant_model #(.START_INIT(SAT_IN)) dut_sat (
        .clock(clock), .reset(reset), .inflow_en(inflow_en), .pumps(pumps),
        .clear_alarms(clear_alarms), .level_sensors(s_level_sensors), .level(s_level),
        .overflow(s_overflow), .dry_run(s_dry_run), .b1_starts(s_b1_starts),
        .b2_starts(s_b2_starts)
    );

    always #5 clock = ~clock;

    typedef struct {
        int lvl;
        int sens;
        int ovf;
        int dry;
        int b1;
        int b2;
        int sb1;
        int sb2;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model state
    int       m_lvl, m_ovf, m_dry, m_b1, m_b2, m_sb1, m_sb2;
    bit [1:0] m_prev;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_lvl  = LINIT;
        m_ovf  = 0;
        m_dry  = 0;
        m_b1   = 0;
        m_b2   = 0;
        m_sb1  = SAT_IN;
        m_sb2  = SAT_IN;
        m_prev = 2'b00;
    endfunction

    function automatic int bump(int c, bit rise);
        return (rise && c < 65535) ? c + 1 : c;
    endfunction

    function automatic void model_step(bit inf, bit [1:0] p, bit clr);
        int raw;
        raw   = m_lvl + (inf ? INF : 0) - RATE * $countones(p);
        m_ovf = (raw > LMAX) || (m_ovf != 0 && !clr);
        m_dry = (raw < 0 && p != 0) || (m_dry != 0 && !clr);
        m_lvl = (raw > LMAX) ? LMAX : (raw < 0) ? 0 : raw;
        m_b1  = bump(m_b1, p[0] && !m_prev[0]);
        m_b2  = bump(m_b2, p[1] && !m_prev[1]);
        m_sb1 = bump(m_sb1, p[0] && !m_prev[0]);
        m_sb2 = bump(m_sb2, p[1] && !m_prev[1]);
        m_prev = p;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.lvl  = m_lvl;
        e.sens = (m_lvl >= TH_S ? 2 : 0) + (m_lvl >= TH_I ? 1 : 0);
        e.ovf  = m_ovf;
        e.dry  = m_dry;
        e.b1   = m_b1;
        e.b2   = m_b2;
        e.sb1  = m_sb1;
        e.sb2  = m_sb2;
        return e;
    endfunction

    // One cycle of stimulus; the expected post-edge state goes to the scoreboard.
    task automatic step(input bit rst, input bit inf, input bit [1:0] p, input bit clr);
        @(negedge clock);
        reset        = rst;
        inflow_en    = inf;
        pumps        = p;
        clear_alarms = clr;
        if (!rst) model_reset();
        else      model_step(inf, p, clr);
        q.push_back(snapshot());
    endtask

    task automatic repeat_step(input int n, input bit inf, input bit [1:0] p);
        for (int i = 0; i < n; i++) step(1'b1, inf, p, 1'b0);
    endtask

    task automatic rand_reset(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom), 2'($urandom), 1'($urandom));
    endtask

    // Direct look at the DUT just after the edge of the last step.
    task automatic after_edge();
        @(posedge clock);
        #2;
    endtask

    // Monitor: one expected entry per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("level", int'(level), e.lvl);
                check("level_sensors", int'(level_sensors), e.sens);
                check("overflow", int'(overflow), e.ovf);
                check("dry_run", int'(dry_run), e.dry);
                check("b1_starts", int'(b1_starts), e.b1);
                check("b2_starts", int'(b2_starts), e.b2);
                check("sat_b1_starts", int'(s_b1_starts), e.sb1);
                check("sat_b2_starts", int'(s_b2_starts), e.sb2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        model_reset();

        // Reset held with random inputs, then fill to 180 and reset asynchronously
        rand_reset(5);
        repeat_step(40, 1'b1, 2'b00);
        after_edge();
        check("fill_to_180", int'(level), 180);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_level", int'(level), LINIT);
        check("async_rst_sensors", int'(level_sensors), 1);
        check("async_rst_overflow", int'(overflow), 0);
        check("async_rst_b1", int'(b1_starts), 0);
        model_reset();
        rand_reset(3);

        // Fill to threshold, ceiling, then overflow
        repeat_step(25, 1'b1, 2'b00);
        after_edge();
        check("fill25_level", int'(level), 150);
        check("fill25_sensors", int'(level_sensors), 3);
        repeat_step(25, 1'b1, 2'b00);
        after_edge();
        check("fill50_level", int'(level), 200);
        check("fill50_overflow", int'(overflow), 0);
        repeat_step(1, 1'b1, 2'b00);
        after_edge();
        check("fill51_level", int'(level), 200);
        check("fill51_overflow", int'(overflow), 1);

        // Alarm clear: works below the ceiling, loses to a same-cycle overflow
        step(1'b1, 1'b0, 2'b00, 1'b1);
        after_edge();
        check("clear_overflow", int'(overflow), 0);
        step(1'b1, 1'b1, 2'b00, 1'b0);
        step(1'b1, 1'b1, 2'b00, 1'b1);
        after_edge();
        check("clear_vs_set", int'(overflow), 1);

        // Double drain down to dry run
        rand_reset(2);
        repeat_step(12, 1'b1, 2'b11);
        after_edge();
        check("dd12_level", int'(level), 52);
        check("dd12_sensors", int'(level_sensors), 1);
        repeat_step(1, 1'b1, 2'b11);
        after_edge();
        check("dd13_level", int'(level), 48);
        check("dd13_sensors", int'(level_sensors), 0);
        repeat_step(12, 1'b1, 2'b11);
        after_edge();
        check("dd25_level", int'(level), 0);
        check("dd25_dry", int'(dry_run), 0);
        repeat_step(1, 1'b1, 2'b11);
        after_edge();
        check("dd26_level", int'(level), 0);
        check("dd26_dry", int'(dry_run), 1);

        // Single drain across the I threshold
        rand_reset(2);
        repeat_step(50, 1'b1, 2'b01);
        after_edge();
        check("sd50_level", int'(level), 50);
        check("sd50_sensors", int'(level_sensors), 1);
        repeat_step(1, 1'b1, 2'b01);
        after_edge();
        check("sd51_level", int'(level), 49);
        check("sd51_sensors", int'(level_sensors), 0);

        // Start counting and saturation
        rand_reset(2);
        step(1'b1, 1'b0, 2'b01, 1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b0, 2'b10, 1'b0);
        step(1'b1, 1'b0, 2'b11, 1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b0);
        after_edge();
        check("seq_b1", int'(b1_starts), 2);
        check("seq_b2", int'(b2_starts), 1);
        check("seq_sat_b1", int'(s_b1_starts), 'hFFFF);
        check("seq_sat_b2", int'(s_b2_starts), 'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 2'b11, 1'b0);
            step(1'b1, 1'b1, 2'b00, 1'b0);
        end
        after_edge();
        check("tog_b1", int'(b1_starts), 5);
        check("tog_sat_b2", int'(s_b2_starts), 'hFFFF);

        // Random traffic with occasional clears and resets
        rand_reset(2);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) != 0),
                 2'($urandom), ($urandom_range(0, 7) == 0));
        end

        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        #3;
        if (q.size() > 0) check("scoreboard_drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/tank_plant_model.md
# tank_plant_model

Cycle-based behavioural model of the tank, water inflow and two pumps driven by the pump-alternation controller. It consumes the controller's `pumps` command and produces the `level_sensors` inputs it expects, closing the loop for system-level simulation and on-board demo. It integrates the water level per clock, derives the low (I) and high (S) sensors from thresholds, and reports overflow and dry-run alarms. It also counts pump starts so the bench can check B1/B2 alternation.

## Interface
- `LEVEL_W`, 8: width of the level register and threshold parameters.
- `LEVEL_MAX`, 200: saturation ceiling of the level, must be < 2^LEVEL_W.
- `LEVEL_INIT`, 100: level loaded on reset.
- `THRESH_I`, 50: I sensor active when level >= THRESH_I.
- `THRESH_S`, 150: S sensor active when level >= THRESH_S; must be > THRESH_I.
- `INFLOW`, 2: level units added per cycle while `inflow_en`=1.
- `PUMP_RATE`, 3: level units removed per cycle per running pump.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `inflow_en`  in  1  enables water inflow this cycle.
- `pumps`  in  2  bit0 = B1 running, bit1 = B2 running (controller output).
- `clear_alarms`  in  1  synchronous clear of sticky alarms.
- `level_sensors`  out  2  registered; bit0 = I sensor, bit1 = S sensor.
- `level`  out  LEVEL_W  current water level, registered.
- `overflow`  out  1  sticky: inflow attempted beyond LEVEL_MAX.
- `dry_run`  out  1  sticky: a pump was commanded with insufficient water.
- `b1_starts`  out  16  count of 0->1 transitions of pumps[0], saturating.
- `b2_starts`  out  16  count of 0->1 transitions of pumps[1], saturating.

## Operation
- Reset values: `level`=LEVEL_INIT, `level_sensors` derived from LEVEL_INIT (2'b01 with defaults), `overflow`=0, `dry_run`=0, both start counters 0, internal previous-pumps register 2'b00.
- Per rising edge: raw = level + (inflow_en ? INFLOW : 0) - PUMP_RATE * popcount(pumps). Compute in signed LEVEL_W+3 bits; no wrap-around permitted.
- Level update: raw > LEVEL_MAX -> LEVEL_MAX; raw < 0 -> 0; otherwise raw.
- `level_sensors` updated on the same edge from the new (saturated) level: bit0 = new >= THRESH_I, bit1 = new >= THRESH_S. Value 2'b10 is never produced.
- `overflow` set when raw > LEVEL_MAX. `dry_run` set when raw < 0 and pumps != 0.
- `clear_alarms`=1 clears both flags, except that a set condition in the same cycle wins (flag stays 1).
- Start counters: increment when pumps[i]=1 and previous pumps[i]=0; hold at 16'hFFFF. Previous-pumps register updates every cycle. Not cleared by `clear_alarms`.
- Illegal parameter set (THRESH_S <= THRESH_I, LEVEL_MAX >= 2^LEVEL_W, LEVEL_INIT > LEVEL_MAX): simulation `$error` at elaboration.

## Timing
- All outputs are registered. There is no combinational path from `pumps` or `inflow_en` to any output, so the loop with the Mealy controller is free of combinational loops.
- Latency: a `pumps` or `inflow_en` change sampled at edge N is reflected in `level`, `level_sensors`, alarms and counters after edge N.
- Asynchronous reset assertion mid-operation forces all reset values immediately, independent of `clock`. Deassertion is synchronised externally. The first update happens on the first edge with `reset`=1.
- Boundary at a threshold: level equal to a threshold counts as sensor active.

## Test plan
- Reset: hold `reset`=0 with clock running and random inputs -> `level`=100, `level_sensors`=2'b01, alarms 0, counters 0. Assert mid-run at level 180 -> same values without waiting for an edge.
- Fill: `inflow_en`=1, `pumps`=00 from 100 -> `level`=150 and `level_sensors`=2'b11 after edge 25. `level`=200 after edge 50. Edge 51 leaves `level`=200 and sets `overflow`=1.
- Double drain: `inflow_en`=1, `pumps`=11 from 100 -> `level`=52 (2'b01) after edge 12, 48 (2'b00) after edge 13, 0 after edge 25. Edge 26 sets `dry_run`=1 and `level` stays 0.
- Single drain: `inflow_en`=1, `pumps`=01 from 100 -> `level`=50 with `level_sensors`=2'b01 after edge 50. `level`=49 with 2'b00 after edge 51.
- Start counting: `pumps` sequence 01,00,10,11,00, one cycle each -> `b1_starts`=2, `b2_starts`=1. Preload near 16'hFFFF and toggle -> saturates at 16'hFFFF.
- Alarm clear: with `overflow`=1, pulse `clear_alarms` while level < LEVEL_MAX -> `overflow`=0 next edge. Pulse during an overflowing cycle -> `overflow` stays 1.
